// File: rtl/div_cu_pkg.sv
// Shared constants for the 4-bit restoring divider control unit.
// Also holds the state encodings and the bundle of control outputs.
package div_cu_pkg;

  localparam int WIDTH = 4;
  localparam int ITER  = 4;
  localparam logic [WIDTH-1:0] ITER_N = WIDTH'(ITER);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] SUB   = 3'd4;
  localparam logic [2:0] FINAL = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [2:0] ERR   = 3'd7;

  typedef struct packed {
    logic ud_ce;
    logic ud_ld;
    logic ud_ud;
    logic s0;
    logic s1;
    logic s2;
    logic r_ld;
    logic r_sl;
    logic r_sr;
    logic x_ld;
    logic x_sl;
    logic x_right_in;
    logic y_ld;
    logic done;
    logic err;
  } ctrl_t;

endpackage

// File: rtl/div_cu.sv
// Control unit for the restoring-division datapath: sequences load, shift and
// subtract steps, builds the quotient bit by bit and flags divide-by-zero.
module div_cu
  import div_cu_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             go,
  input  logic [WIDTH-1:0] R_lt_Y,
  input  logic [WIDTH-1:0] cnt_out,
  input  logic             error,
  output logic             udCE,
  output logic             udLD,
  output logic             udUD,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             rLD,
  output logic             rSL,
  output logic             rSR,
  output logic             xLD,
  output logic             xSL,
  output logic             xRightIn,
  output logic             yLD,
  output logic [WIDTH-1:0] n,
  output logic             done,
  output logic             err
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic       qbit;
  logic       next_qbit;
  ctrl_t      ctrl;
  logic       unused_lt;

  // Only the LSB of the comparator bus carries the R < Y result.
  assign unused_lt = ^R_lt_Y[WIDTH-1:1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      qbit  <= 1'b0;
    end else begin
      state <= next_state;
      qbit  <= next_qbit;
    end
  end

  always_comb begin
    next_state = state;
    next_qbit  = qbit;
    ctrl       = '0;
    case (state)
      IDLE: begin
        if (go) next_state = INIT;
      end
      INIT: begin
        ctrl.x_ld  = 1'b1;
        ctrl.y_ld  = 1'b1;
        ctrl.r_ld  = 1'b1;
        ctrl.ud_ld = 1'b1;
        next_qbit  = 1'b0;
        next_state = CHECK;
      end
      CHECK: begin
        next_state = error ? ERR : SHIFT;
      end
      SHIFT: begin
        ctrl.r_sl       = 1'b1;
        ctrl.x_sl       = 1'b1;
        ctrl.x_right_in = qbit;
        ctrl.ud_ce      = 1'b1;
        next_state      = SUB;
      end
      SUB: begin
        // Restore step: R keeps its value when it is already below Y.
        ctrl.r_ld  = ~R_lt_Y[0];
        ctrl.s0    = ~R_lt_Y[0];
        next_qbit  = ~R_lt_Y[0];
        next_state = (cnt_out == '0) ? FINAL : SHIFT;
      end
      FINAL: begin
        ctrl.x_sl       = 1'b1;
        ctrl.x_right_in = qbit;
        next_state      = DONE;
      end
      DONE: begin
        ctrl.done = 1'b1;
        ctrl.s1   = 1'b1;
        ctrl.s2   = 1'b1;
        if (!go) next_state = IDLE;
      end
      ERR: begin
        ctrl.done = 1'b1;
        ctrl.err  = 1'b1;
        if (!go) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign udCE     = ctrl.ud_ce;
  assign udLD     = ctrl.ud_ld;
  assign udUD     = ctrl.ud_ud;
  assign s0       = ctrl.s0;
  assign s1       = ctrl.s1;
  assign s2       = ctrl.s2;
  assign rLD      = ctrl.r_ld;
  assign rSL      = ctrl.r_sl;
  assign rSR      = ctrl.r_sr;
  assign xLD      = ctrl.x_ld;
  assign xSL      = ctrl.x_sl;
  assign xRightIn = ctrl.x_right_in;
  assign yLD      = ctrl.y_ld;
  assign n        = ITER_N;
  assign done     = ctrl.done;
  assign err      = ctrl.err;

endmodule

// File: tb/tb_div_cu.sv
// Bench for div_cu: a small datapath plant closes the loop, and a job-level
// model (start edge, fixed latency, x/y arithmetic) predicts done/err/q/r.
module tb_div_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [3:0] r_lt_y;
  logic [3:0] cnt_out;
  logic       error;
  logic       ud_ce, ud_ld, ud_ud, s0, s1, s2, r_ld, r_sl, r_sr;
  logic       x_ld, x_sl, x_right_in, y_ld, done, err;
  logic [3:0] n;

  logic [3:0] x_in = 4'd0;
  logic [3:0] y_in = 4'd0;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  div_cu dut (
    .CLK(clk), .RST(rst), .go(go), .R_lt_Y(r_lt_y), .cnt_out(cnt_out), .error(error),
    .udCE(ud_ce), .udLD(ud_ld), .udUD(ud_ud), .s0(s0), .s1(s1), .s2(s2),
    .rLD(r_ld), .rSL(r_sl), .rSR(r_sr), .xLD(x_ld), .xSL(x_sl), .xRightIn(x_right_in),
    .yLD(y_ld), .n(n), .done(done), .err(err)
  );

  // Datapath plant: R/X/Y registers, subtractor, comparator and counter.
  logic [4:0] r_reg = '0;
  logic [3:0] x_reg = '0;
  logic [3:0] y_reg = '0;
  logic [3:0] cnt_reg = '0;
  int         sub_loads = 0;

  always @(posedge clk) begin
    if (y_ld) y_reg <= y_in;
    if (x_ld) x_reg <= x_in;
    else if (x_sl) x_reg <= {x_reg[2:0], x_right_in};
    if (r_ld) r_reg <= s0 ? (r_reg - {1'b0, y_reg}) : 5'd0;
    else if (r_sl) r_reg <= {r_reg[3:0], x_reg[3]};
    if (ud_ld) cnt_reg <= n;
    else if (ud_ce) cnt_reg <= ud_ud ? cnt_reg + 4'd1 : cnt_reg - 4'd1;
    if (r_ld && s0) sub_loads <= sub_loads + 1;
  end

  assign r_lt_y  = {3'b101, (r_reg < {1'b0, y_reg})};
  assign error   = (y_reg == 4'd0);
  assign cnt_out = cnt_reg;

  logic [3:0] q_out;
  logic [3:0] r_out;
  logic [12:0] ctl;
  assign q_out = s2 ? x_reg : 4'd0;
  assign r_out = s1 ? r_reg[3:0] : 4'd0;
  assign ctl = {ud_ce, ud_ld, ud_ud, s0, s1, s2, r_ld, r_sl, r_sr, x_ld, x_sl, x_right_in, y_ld};

  // Job model: a divide starts on the edge that sees go in idle, and its
  // result appears a fixed number of edges later.
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  bit m_err_job = 1'b0;
  int m_k = 0;
  int m_lat = 0;
  int m_q = 0;
  int m_r = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_k      <= 0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (m_done) begin
      if (!go) m_done <= 1'b0;
    end else if (go) begin
      m_active  <= 1'b1;
      m_k       <= 0;
      m_err_job <= (y_in == 4'd0);
      m_lat     <= (y_in == 4'd0) ? 2 : 11;
      m_q       <= (y_in == 4'd0) ? 0 : int'(x_in) / int'(y_in);
      m_r       <= (y_in == 4'd0) ? 0 : int'(x_in) % int'(y_in);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the job model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rSR low", int'(r_sr), 0);
      checkOutput("rLD/rSL exclusive", int'(r_ld & r_sl), 0);
      checkOutput("xLD/xSL exclusive", int'(x_ld & x_sl), 0);
      checkOutput("n constant", int'(n), 4);
      checkOutput("done vs model", int'(done), int'(m_done));
      checkOutput("err vs model", int'(err), int'(m_done & m_err_job));
      if (m_done) begin
        checkOutput("q vs model", int'(q_out), m_q);
        checkOutput("r vs model", int'(r_out), m_r);
      end else if (!m_active) begin
        checkOutput("idle controls", int'(ctl), 0);
      end
      if ((m_active || m_done) && m_err_job)
        checkOutput("no shift on div0", int'(r_sl | x_sl), 0);
    end
  end

  // Starts a divide and waits (bounded) for done; returns edges from start.
  task automatic applyStimulus(input logic [3:0] xv, input logic [3:0] yv,
                               input bit hold_go, input bit noisy, output int lat);
    @(negedge clk);
    x_in = xv;
    y_in = yv;
    go = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      go = noisy ? 1'($urandom) : hold_go;
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) $display("[TB] FAIL done timeout for x=%0d y=%0d", xv, yv);
  endtask

  task automatic returnIdle();
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done cleared", int'(done), 0);
  endtask

  task automatic runCase(input logic [3:0] xv, input logic [3:0] yv,
                         input int exp_q, input int exp_r, input bit exp_err);
    int lat;
    applyStimulus(xv, yv, 1'b0, 1'b0, lat);
    checkOutput("latency", lat, exp_err ? 2 : 11);
    checkOutput("q literal", int'(q_out), exp_q);
    checkOutput("r literal", int'(r_out), exp_r);
    checkOutput("err literal", int'(err), int'(exp_err));
    returnIdle();
  endtask

  initial begin
    int lat;
    int loads_before;
    logic [3:0] xv;
    logic [3:0] yv;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset controls", int'(ctl), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset n", int'(n), 4);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    runCase(4'd13, 4'd4, 3, 1, 1'b0);
    runCase(4'd15, 4'd1, 15, 0, 1'b0);
    loads_before = sub_loads;
    runCase(4'd3, 4'd7, 0, 3, 1'b0);
    checkOutput("no SUB load 3/7", sub_loads - loads_before, 0);
    runCase(4'd9, 4'd0, 0, 0, 1'b1);

    // Reset while the second SUB step is active discards the divide.
    @(negedge clk);
    x_in = 4'd13;
    y_in = 4'd4;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset controls", int'(ctl), 0);
    checkOutput("mid reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    runCase(4'd9, 4'd3, 3, 0, 1'b0);

    // go held across DONE keeps the result on the outputs.
    applyStimulus(4'd13, 4'd4, 1'b1, 1'b0, lat);
    checkOutput("hold latency", lat, 11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold done", int'(done), 1);
      checkOutput("hold q", int'(q_out), 3);
      checkOutput("hold r", int'(r_out), 1);
    end
    returnIdle();

    for (int t = 0; t < 40; t++) begin
      xv = 4'($urandom);
      yv = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      applyStimulus(xv, yv, 1'b0, 1'b1, lat);
      checkOutput("rand latency", lat, (yv == 4'd0) ? 2 : 11);
      checkOutput("rand err", int'(err), int'(yv == 4'd0));
      checkOutput("rand q", int'(q_out), (yv == 4'd0) ? 0 : int'(xv) / int'(yv));
      checkOutput("rand r", int'(r_out), (yv == 4'd0) ? 0 : int'(xv) % int'(yv));
      returnIdle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
